comb_reverb_ram: RTL and testbench



---
 rtl/reverb_pkg.sv | 37 +++
 rtl/comb_reverb_ram_if.sv | 12 +
 rtl/reverb_dpram.sv | 23 ++
 rtl/comb_reverb_ram.sv | 168 ++++++++++++++++
 tb/tb_comb_reverb_ram.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reverb_pkg.sv
// Shared types and helpers for the RAM-backed feedback comb reverb.
// Contents: mix select encodings, FSM state encoding, saturating adder.
package reverb_pkg;

    typedef enum logic [1:0] {
        MIX_WET  = 2'd0,
        MIX_HALF = 2'd1,
        MIX_DRY  = 2'd2,
        MIX_ECHO = 2'd3
    } mix_e;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_CALC  = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    // Adds two sign-extended samples and clamps to the signed range of w bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned       w);
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] res;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo  = -(32'sd1 <<< (w - 32'd1));
        res = sum;
        if (sum > hi) res = hi;
        if (sum < lo) res = lo;
        return res;
    endfunction

endpackage

// File: rtl/comb_reverb_ram_if.sv
// Valid/ready sample stream used on both sides of the reverb.
// Signals: data (signed sample), valid (producer), ready (consumer).
interface comb_reverb_ram_if #(
    parameter int unsigned DATA_W = 16
);
    logic signed [DATA_W-1:0] data;
    logic                     valid;
    logic                     ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/reverb_dpram.sv
// Simple dual-port RAM holding the delay line: one write port, one
// synchronous read port with 1-cycle latency.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module reverb_dpram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/comb_reverb_ram.sv
// Feedback comb reverb y[n] = sat(x[n] + (y[n-D] >>> fb_shift)) with the
// delay line in a circular RAM. One sample in flight at a time.
// Ports: clk, rst (sync, active-high), s (input stream), m (output stream),
//        delay_len, fb_shift, mix, enable (sampled at accept),
//        clear (flush request), clr_busy (flush in progress).
module comb_reverb_ram
    import reverb_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DELAY_MAX = 4096,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    comb_reverb_ram_if.slave       s,
    comb_reverb_ram_if.master      m,
    input  logic [ADDR_W-1:0]      delay_len,
    input  logic [2:0]             fb_shift,
    input  logic [1:0]             mix,
    input  logic                   enable,
    input  logic                   clear,
    output logic                   clr_busy
);
    state_e                   state;
    logic [ADDR_W-1:0]        clr_cnt;
    logic [ADDR_W-1:0]        wr_ptr;
    logic signed [DATA_W-1:0] x_q;
    logic [ADDR_W-1:0]        dly_q;
    logic [2:0]               sh_q;
    mix_e                     mix_q;
    logic                     en_q;
    logic                     clr_pend;
    logic                     wr_first;
    logic signed [DATA_W-1:0] wr_q;

    logic [DATA_W-1:0]        ram_rdata;
    logic                     ram_we_c;
    logic [ADDR_W-1:0]        ram_waddr_c;
    logic [DATA_W-1:0]        ram_wdata_c;
    logic [ADDR_W-1:0]        rd_addr_c;
    logic signed [DATA_W-1:0] d_c;
    logic signed [DATA_W-1:0] fb_c;
    logic signed [DATA_W-1:0] y_c;
    logic signed [DATA_W:0]   sum_c;
    logic signed [DATA_W-1:0] sel_c;

    reverb_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DELAY_MAX),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .raddr (rd_addr_c),
        .rdata (ram_rdata)
    );

    // RAM port steering: flush writes zeros, OUT writes the result once.
    always_comb begin
        ram_we_c    = (state == ST_CLEAR) || ((state == ST_OUT) && wr_first);
        ram_waddr_c = wr_ptr;
        ram_wdata_c = wr_q;
        if (state == ST_CLEAR) begin
            ram_waddr_c = clr_cnt;
            ram_wdata_c = '0;
        end
        // A delay of 0 would read the slot about to be written; treat as 1.
        rd_addr_c = wr_ptr - ((dly_q == '0) ? ADDR_W'(1) : dly_q);
    end

    // Comb datapath evaluated in CALC from the latched sample and RAM data.
    always_comb begin
        d_c  = signed'(ram_rdata);
        fb_c = d_c >>> sh_q;
        if (sh_q == 3'd0) fb_c = '0;
        y_c   = DATA_W'(sat_add(32'(x_q), 32'(fb_c), DATA_W));
        sum_c = (DATA_W+1)'(x_q) + (DATA_W+1)'(y_c);
        case (mix_q)
            MIX_WET:  sel_c = y_c;
            MIX_HALF: sel_c = DATA_W'(sum_c >>> 1);
            MIX_DRY:  sel_c = x_q;
            default:  sel_c = fb_c;
        endcase
        if (!en_q) sel_c = x_q;
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            wr_ptr   <= '0;
            clr_busy <= 1'b1;
            s.ready  <= 1'b0;
            m.valid  <= 1'b0;
            m.data   <= '0;
            x_q      <= '0;
            dly_q    <= '0;
            sh_q     <= '0;
            mix_q    <= MIX_WET;
            en_q     <= 1'b0;
            clr_pend <= 1'b0;
            wr_first <= 1'b0;
            wr_q     <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DELAY_MAX - 1)) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                        s.ready  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    // clear wins over a simultaneous sample
                    if (clear) begin
                        state    <= ST_CLEAR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                        s.ready  <= 1'b0;
                    end else if (s.valid) begin
                        x_q     <= s.data;
                        dly_q   <= delay_len;
                        sh_q    <= fb_shift;
                        mix_q   <= mix_e'(mix);
                        en_q    <= enable;
                        s.ready <= 1'b0;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    clr_pend <= clr_pend | clear;
                    state    <= ST_CALC;
                end
                ST_CALC: begin
                    clr_pend <= clr_pend | clear;
                    m.data   <= sel_c;
                    m.valid  <= 1'b1;
                    wr_q     <= en_q ? y_c : x_q;
                    wr_first <= 1'b1;
                    state    <= ST_OUT;
                end
                ST_OUT: begin
                    wr_first <= 1'b0;
                    if (m.ready) begin
                        m.valid <= 1'b0;
                        wr_ptr  <= wr_ptr + 1'b1;
                        if (clr_pend || clear) begin
                            state    <= ST_CLEAR;
                            clr_cnt  <= '0;
                            clr_busy <= 1'b1;
                            clr_pend <= 1'b0;
                        end else begin
                            state   <= ST_IDLE;
                            s.ready <= 1'b1;
                        end
                    end else begin
                        clr_pend <= clr_pend | clear;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_comb_reverb_ram.sv
// Self-checking bench for comb_reverb_ram: directed echo/saturation/mode/flush
// scenarios plus randomized samples, compared against an array-based model.
module tb_comb_reverb_ram;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] delay_len;
    logic [2:0]        fb_shift;
    logic [1:0]        mix;
    logic              enable;
    logic              clear;
    logic              clr_busy;

    comb_reverb_ram_if #(.DATA_W(DATA_W)) s_if ();
    comb_reverb_ram_if #(.DATA_W(DATA_W)) m_if ();

    comb_reverb_ram #(
        .DATA_W    (DATA_W),
        .DELAY_MAX (DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s_if),
        .m         (m_if),
        .delay_len (delay_len),
        .fb_shift  (fb_shift),
        .mix       (mix),
        .enable    (enable),
        .clear     (clear),
        .clr_busy  (clr_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mbuf [DEPTH];
    int mwp = 0;
    int res [16];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: y = clamp(x + floor(d / 2^sh)), history indexed by sample count.
    task automatic model_calc(input int x, input int dl, input int sh, input int mx,
                              input int en, output int out, output int wv);
        int dd, d, fb, y;
        dd = (dl == 0) ? 1 : dl;
        d  = mbuf[(mwp - dd + DEPTH) % DEPTH];
        fb = (sh == 0) ? 0 : (d >>> sh);
        y  = x + fb;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        case (mx)
            0:       out = y;
            1:       out = (x + y) >>> 1;
            2:       out = x;
            default: out = fb;
        endcase
        if (en == 0) begin
            out = x;
            wv  = x;
        end else begin
            wv = y;
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) mbuf[i] = 0;
    endtask

    // Called at a negedge just after the cycle in which the flush started.
    task automatic measure_flush(input string tag);
        int n;
        int seen_valid;
        int busy_low;
        n = 0;
        seen_valid = 0;
        busy_low = 0;
        while (!s_if.ready && n < 10000) begin
            if (m_if.valid) seen_valid = 1;
            if (!clr_busy) busy_low = 1;
            n++;
            @(negedge clk);
        end
        check({tag, "_len"}, n, 4096);
        check({tag, "_busy_during"}, busy_low, 0);
        check({tag, "_mvalid_during"}, seen_valid, 0);
        check({tag, "_busy_after"}, int'(clr_busy), 0);
    endtask

    task automatic do_clear(input string tag);
        int n;
        @(negedge clk);
        n = 0;
        while (!s_if.ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        measure_flush(tag);
        model_zero();
    endtask

    // action: 0 normal, 1 clear asserted in CALC, 2 reset asserted in CALC
    task automatic send(input int x, input int dl, input int sh, input int mx, input int en,
                        input int stall, input int action, output int got);
        int exp_out, wv, n, lat;
        got = 0;
        model_calc(x, dl, sh, mx, en, exp_out, wv);
        @(negedge clk);
        s_if.data  = DATA_W'(x);
        s_if.valid = 1'b1;
        delay_len  = ADDR_W'(dl);
        fb_shift   = 3'(sh);
        mix        = 2'(mx);
        enable     = 1'(en);
        n = 0;
        while (!s_if.ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!s_if.ready) begin
            s_if.valid = 1'b0;
            check("accept_timeout", int'(s_if.ready), 1);
            return;
        end
        @(posedge clk);
        #1;
        // Parameters must have been captured at accept; scramble them now.
        s_if.valid = 1'b0;
        s_if.data  = DATA_W'($urandom);
        delay_len  = ADDR_W'($urandom);
        fb_shift   = 3'($urandom);
        mix        = 2'($urandom);
        enable     = 1'($urandom);
        if (action == 2) begin
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            measure_flush("rst_calc");
            model_zero();
            mwp = 0;
            return;
        end
        lat = 0;
        while (!m_if.valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (action == 1 && lat == 2) clear = 1'b1;
            if (action == 1 && lat == 3) clear = 1'b0;
        end
        check("latency", lat, 3);
        if (!m_if.valid) return;
        got = int'(m_if.data);
        check("out", got, exp_out);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_data", int'(m_if.data), exp_out);
            check("hold_valid", int'(m_if.valid), 1);
            check("hold_s_ready", int'(s_if.ready), 0);
        end
        m_if.ready = 1'b1;
        @(posedge clk);
        #1 m_if.ready = 1'b0;
        check("valid_drop", int'(m_if.valid), 0);
        mbuf[mwp] = wv;
        mwp = (mwp + 1) % DEPTH;
        if (action == 1) model_zero();
    endtask

    task automatic run_impulse(input int amp, input int dl, input int sh, input int mx,
                               input int en, input int len);
        for (int i = 0; i < len; i++) send((i == 0) ? amp : 0, dl, sh, mx, en, 0, 0, res[i]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int x, dl;
        s_if.data  = '0;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        delay_len  = '0;
        fb_shift   = '0;
        mix        = '0;
        enable     = 1'b1;
        clear      = 1'b0;
        model_zero();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", int'(m_if.valid), 0);
        check("rst_m_data", int'(m_if.data), 0);
        check("rst_s_ready", int'(s_if.ready), 0);
        check("rst_clr_busy", int'(clr_busy), 1);
        rst = 1'b0;
        measure_flush("reset_flush");

        // Impulse through D=4, half-gain feedback
        run_impulse(16384, 4, 1, 0, 1, 12);
        check("imp_n0", res[0], 16384);
        check("imp_n1", res[1], 0);
        check("imp_n4", res[4], 8192);
        check("imp_n5", res[5], 0);
        check("imp_n8", res[8], 4096);

        // Saturation with D=1
        do_clear("clr_sat");
        for (int i = 0; i < 6; i++) begin
            send(30000, 1, 1, 0, 1, 0, 0, g);
            if (i == 0) check("sat_pos_first", g, 30000);
        end
        check("sat_pos_last", g, 32767);
        do_clear("clr_satn");
        for (int i = 0; i < 6; i++) send(-32768, 1, 1, 0, 1, 0, 0, g);
        check("sat_neg_last", g, -32768);

        // Output modes
        do_clear("clr_echo");
        run_impulse(16384, 4, 1, 3, 1, 6);
        check("echo_n0", res[0], 0);
        check("echo_n4", res[4], 8192);
        do_clear("clr_half");
        run_impulse(16384, 4, 1, 1, 1, 6);
        check("half_n0", res[0], 16384);
        do_clear("clr_nofb");
        run_impulse(16384, 4, 0, 0, 1, 9);
        check("nofb_n0", res[0], 16384);
        check("nofb_n4", res[4], 0);
        do_clear("clr_bypass");
        run_impulse(16384, 4, 1, 0, 0, 9);
        check("bypass_n0", res[0], 16384);
        check("bypass_n4", res[4], 0);

        // Backpressure, then a normal sample
        send(1000, 4, 1, 0, 1, 10, 0, g);
        send(500, 4, 1, 0, 1, 0, 0, g);

        // clear during an echo tail, then look for residue
        do_clear("clr_tail");
        run_impulse(16384, 4, 1, 0, 1, 8);
        send(0, 4, 1, 0, 1, 0, 1, g);
        check("tail_out", g, 4096);
        @(negedge clk);
        measure_flush("clr_calc");
        run_impulse(16384, 4, 1, 0, 1, 9);
        check("post_clr_n0", res[0], 16384);
        check("post_clr_n3", res[3], 0);
        check("post_clr_n4", res[4], 8192);
        check("post_clr_n8", res[8], 4096);

        // Reset in CALC
        send(1234, 4, 1, 0, 1, 0, 2, g);
        send(777, 1, 1, 0, 1, 0, 0, g);
        check("post_rst", g, 777);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            x  = int'($urandom_range(0, 65535)) - 32768;
            dl = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 8))
                                             : int'($urandom_range(0, 4095));
            send(x, dl, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) != 0) ? 1 : 0, int'($urandom_range(0, 3)), 0, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
